// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide issue path: scheduler states,
// default widths and the whichMath encodings used by decode.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    WB   = 2'd3
  } sched_state_e;

  localparam int unsigned DEFAULT_DATA_W = 64;
  localparam int unsigned DEFAULT_TAG_W  = 6;

  localparam logic [1:0] MATH_MULT = 2'd2;
  localparam logic [1:0] MATH_DIV  = 2'd3;

endpackage

// File: rtl/muldiv_issue_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// wrapping, plus the encoded index of the winner.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  logic          found;
  logic [IW-1:0] cand;

  // Scan offsets from ptr upward; the lowest offset with a request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/muldiv_issue_sched.sv
// Issue scheduler for the shared multi-cycle mult/div unit: round-robin pick
// among ready slots, latency count, result capture and CDB handshake.
module muldiv_issue_sched
  import muldiv_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned TAG_W    = DEFAULT_TAG_W,
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_is_div_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      fu_start_o,
  output logic                      fu_div_o,
  output logic [DATA_W-1:0]         fu_a_o,
  output logic [DATA_W-1:0]         fu_b_o,
  input  logic [DATA_W-1:0]         fu_result_i,
  output logic                      cdb_valid_o,
  output logic [TAG_W-1:0]          cdb_tag_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  input  logic                      cdb_ready_i,
  input  logic                      flush_i,
  output logic                      busy_o
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              fu_start_d, fu_div_d, cdb_valid_d, busy_d;
  logic [DATA_W-1:0] fu_a_d, fu_b_d, cdb_data_d;
  logic [TAG_W-1:0]  cdb_tag_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               arb_en;
  logic               accept;

  // Grants only offered from IDLE, never while squashing or held in reset.
  assign arb_en = (state_q == IDLE) && !flush_i && reset_n;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign accept      = |gnt;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    count_d     = count_q;
    tag_d       = tag_q;
    fu_start_d  = 1'b0;
    fu_div_d    = fu_div_o;
    fu_a_d      = fu_a_o;
    fu_b_d      = fu_b_o;
    cdb_valid_d = cdb_valid_o;
    cdb_tag_d   = cdb_tag_o;
    cdb_data_d  = cdb_data_o;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          fu_a_d     = req_a_i[32'(gnt_idx)*DATA_W +: DATA_W];
          fu_b_d     = req_b_i[32'(gnt_idx)*DATA_W +: DATA_W];
          tag_d      = req_tag_i[32'(gnt_idx)*TAG_W +: TAG_W];
          fu_div_d   = req_is_div_i[gnt_idx];
          fu_start_d = 1'b1;
          state_d    = req_is_div_i[gnt_idx] ? DIV : MULT;
          count_d    = req_is_div_i[gnt_idx] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
          rr_ptr_d   = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
        end
      end
      MULT, DIV: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          cdb_data_d  = fu_result_i;
          cdb_tag_d   = tag_q;
          cdb_valid_d = 1'b1;
          state_d     = WB;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      WB: begin
        // A flush coinciding with cdb_ready_i still means "not delivered".
        if (flush_i || cdb_ready_i) begin
          cdb_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      tag_q       <= '0;
      fu_start_o  <= 1'b0;
      fu_div_o    <= 1'b0;
      fu_a_o      <= '0;
      fu_b_o      <= '0;
      cdb_valid_o <= 1'b0;
      cdb_tag_o   <= '0;
      cdb_data_o  <= '0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      tag_q       <= tag_d;
      fu_start_o  <= fu_start_d;
      fu_div_o    <= fu_div_d;
      fu_a_o      <= fu_a_d;
      fu_b_o      <= fu_b_d;
      cdb_valid_o <= cdb_valid_d;
      cdb_tag_o   <= cdb_tag_d;
      cdb_data_o  <= cdb_data_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_muldiv_issue_sched.sv
// Directed and randomized bench for muldiv_issue_sched with a stub mult/div
// unit and a transaction-level reference for grants, latency and results.
module tb_muldiv_issue_sched;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int TW = 6;
  localparam int ML = 4;
  localparam int DL = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid_i, req_is_div_i, req_ready_o;
  logic [N*DW-1:0] req_a_i, req_b_i;
  logic [N*TW-1:0] req_tag_i;
  logic            fu_start_o, fu_div_o, cdb_valid_o, cdb_ready_i, flush_i, busy_o;
  logic [DW-1:0]   fu_a_o, fu_b_o, fu_result_i, cdb_data_o;
  logic [TW-1:0]   cdb_tag_o;

  int compared   = 0;
  int mismatched = 0;
  int mptr       = 0;
  int age        = 100;

  always #5 clk = ~clk;

  muldiv_issue_sched #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_is_div_i(req_is_div_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
    .req_ready_o(req_ready_o),
    .fu_start_o(fu_start_o), .fu_div_o(fu_div_o), .fu_a_o(fu_a_o), .fu_b_o(fu_b_o),
    .fu_result_i(fu_result_i),
    .cdb_valid_o(cdb_valid_o), .cdb_tag_o(cdb_tag_o), .cdb_data_o(cdb_data_o),
    .cdb_ready_i(cdb_ready_i), .flush_i(flush_i), .busy_o(busy_o)
  );

  function automatic logic [63:0] model_fu(input logic [63:0] a, input logic [63:0] b, input logic d);
    if (d) return (b == 64'd0) ? '1 : a / b;
    return a * b;
  endfunction

  // Stub unit: the result is only correct during the LAT-th cycle counted from the start pulse.
  always @(posedge clk) age <= fu_start_o ? 2 : ((age < 100) ? age + 1 : age);
  assign fu_result_i = (((fu_start_o ? 1 : age) == (fu_div_o ? DL : ML)))
                       ? model_fu(fu_a_o, fu_b_o, fu_div_o) : 64'hBAD0_BAD0_BAD0_BAD0;

  function automatic int model_pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) if (mask[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_slots();
    for (int s = 0; s < N; s++) begin
      req_a_i[s*DW +: DW]  = {$urandom, $urandom};
      req_b_i[s*DW +: DW]  = 64'($urandom) | 64'd1;
      req_tag_i[s*TW +: TW] = TW'($urandom);
      req_is_div_i[s]      = 1'($urandom);
    end
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (cdb_valid_o !== 1'b0) hits++;
    end
    check(tag, 64'(hits), 64'd0);
  endtask

  // One transaction: grant, start, latency, result, optional backpressure or flush.
  task automatic do_op(input logic [N-1:0] mask, input int bp, input int flush_k, input bit flush_wb);
    int g, lat, n;
    logic [63:0] ea, eb, er;
    logic [TW-1:0] et;
    logic ed;
    req_valid_i = mask;
    cdb_ready_i = (bp == 0);
    flush_i     = 1'b0;
    #1;
    g = model_pick(mask);
    check("grant", 64'(req_ready_o), 64'd1 << g);
    check("idle_busy", 64'(busy_o), 64'd0);
    ea  = req_a_i[g*DW +: DW];
    eb  = req_b_i[g*DW +: DW];
    et  = req_tag_i[g*TW +: TW];
    ed  = req_is_div_i[g];
    lat = ed ? DL : ML;
    er  = model_fu(ea, eb, ed);
    mptr = (g + 1) % N;
    tick();
    load_slots();
    #1;
    check("start", 64'(fu_start_o), 64'd1);
    check("fu_div", 64'(fu_div_o), 64'(ed));
    check("fu_a", fu_a_o, ea);
    check("fu_b", fu_b_o, eb);
    check("ready_busy", 64'(req_ready_o), 64'd0);
    n = 1;
    while (!cdb_valid_o && n < 40) begin
      check("busy", 64'(busy_o), 64'd1);
      if (flush_k != 0 && n == flush_k) begin
        flush_i = 1'b1;
        tick();
        flush_i     = 1'b0;
        req_valid_i = '0;
        check("flush_idle", 64'(busy_o), 64'd0);
        check("flush_novalid", 64'(cdb_valid_o), 64'd0);
        watch_quiet("flush_quiet", 25);
        return;
      end
      tick();
      n++;
      if (n == 2) check("start_pulse", 64'(fu_start_o), 64'd0);
    end
    check("latency", 64'(n), 64'(lat + 1));
    check("cdb_data", cdb_data_o, er);
    check("cdb_tag", 64'(cdb_tag_o), 64'(et));
    check("wb_busy", 64'(busy_o), 64'd1);
    if (flush_wb) begin
      flush_i     = 1'b1;
      cdb_ready_i = 1'b1;
      tick();
      flush_i     = 1'b0;
      req_valid_i = '0;
      check("wbflush_valid", 64'(cdb_valid_o), 64'd0);
      check("wbflush_busy", 64'(busy_o), 64'd0);
      watch_quiet("wbflush_quiet", 20);
      return;
    end
    for (int i = 0; i < bp; i++) begin
      check("bp_ready", 64'(req_ready_o), 64'd0);
      tick();
      check("bp_valid", 64'(cdb_valid_o), 64'd1);
      check("bp_data", cdb_data_o, er);
      check("bp_tag", 64'(cdb_tag_o), 64'(et));
    end
    cdb_ready_i = 1'b1;
    tick();
    check("valid_drop", 64'(cdb_valid_o), 64'd0);
    check("back_idle", 64'(busy_o), 64'd0);
  endtask

  initial begin
    int g;
    reset_n      = 1'b0;
    req_valid_i  = '1;
    cdb_ready_i  = 1'b1;
    flush_i      = 1'b0;
    load_slots();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(cdb_valid_o), 64'd0);
    check("rst_start", 64'(fu_start_o), 64'd0);
    check("rst_data", cdb_data_o, 64'd0);
    reset_n = 1'b1;

    // Fairness with every slot requesting: 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++) begin
      load_slots();
      do_op('1, 0, 0, 0);
    end
    // Only slots 1 and 3 with the pointer at 2: 3 then 1.
    for (int i = 0; i < 2; i++) begin
      load_slots();
      do_op(4'b1010, 0, 0, 0);
    end

    load_slots();
    req_a_i[2*DW +: DW] = 64'd6;
    req_b_i[2*DW +: DW] = 64'd7;
    req_tag_i[2*TW +: TW] = 6'h11;
    req_is_div_i[2] = 1'b0;
    do_op(4'b0100, 0, 0, 0);

    load_slots();
    req_a_i[0 +: DW] = 64'd100;
    req_b_i[0 +: DW] = 64'd7;
    req_is_div_i[0] = 1'b1;
    do_op(4'b0001, 0, 0, 0);

    load_slots();
    do_op('1, 3, 0, 0);

    // A flush in IDLE suppresses the grant.
    req_valid_i = '1;
    flush_i     = 1'b1;
    #1;
    check("idle_flush_ready", 64'(req_ready_o), 64'd0);
    flush_i = 1'b0;

    load_slots();
    req_is_div_i = '1;
    do_op('1, 0, 11, 0);
    load_slots();
    do_op('1, 0, 0, 1);

    for (int i = 0; i < 16; i++) begin
      load_slots();
      do_op(N'($urandom_range(1, 15)), $urandom_range(0, 2), 0, 0);
    end

    // Asynchronous reset in the middle of a multiply.
    load_slots();
    req_is_div_i = '0;
    req_valid_i  = '1;
    #1;
    g = model_pick(req_valid_i);
    check("pre_rst_grant", 64'(req_ready_o), 64'd1 << g);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_a", fu_a_o, 64'd0);
    check("mid_rst_b", fu_b_o, 64'd0);
    check("mid_rst_ready", 64'(req_ready_o), 64'd0);
    check("mid_rst_tag", 64'(cdb_tag_o), 64'd0);
    tick();
    reset_n     = 1'b1;
    req_valid_i = '0;
    mptr        = 0;
    watch_quiet("post_rst_quiet", 20);
    load_slots();
    do_op('1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
